// File: rtl/l2_array_pkg.sv
// Shared types and helpers for the multi-way L2 storage array.
package l2_array_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    function automatic int bytes_per_entry(input int width);
        return width / BYTE_W;
    endfunction

    // One byte lane of a masked write: take the new byte only where enabled.
    function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old_b,
                                                     input logic [BYTE_W-1:0] new_b,
                                                     input logic              en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/l2_way_bank.sv
// One way of the L2 array: 2**S_INDEX entries, byte-masked write, registered read.
module l2_way_bank
    import l2_array_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S_INDEX-1:0] index,
    input  logic               we,
    input  logic [WIDTH/8-1:0] mbe,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   word,
    output logic [WIDTH-1:0]   merged,
    input  logic               re,
    input  logic [WIDTH-1:0]   rd_next,
    output logic [WIDTH-1:0]   rdata
);

    localparam int NBYTES = bytes_per_entry(WIDTH);

    logic [WIDTH-1:0] mem [2**S_INDEX];

    assign word = mem[index];

    // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        merged = word;
        for (int b = 0; b < NBYTES; b++) begin
            merged[b*BYTE_W +: BYTE_W] = byte_merge(word[b*BYTE_W +: BYTE_W],
                                                    wdata[b*BYTE_W +: BYTE_W], mbe[b]);
        end
    end

    // NOTE: storage is deliberately left out of reset; the INIT sweep clears it so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= merged;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_next;
        end
    end

endmodule

// File: rtl/l2_array_mw.sv
// Multi-way L2 storage array with init sweep, per-way byte-masked writes and write-first reads.
// Define L2_ARRAY_OUTREG_EN to add a second output register stage (read latency 2).
module l2_array_mw
    import l2_array_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 256,
    parameter int WAYS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic [WAYS-1:0]       load,
    input  logic [WIDTH/8-1:0]    mbe,
    input  logic [S_INDEX-1:0]    index,
    input  logic [WIDTH-1:0]      datain,
    output logic [WAYS*WIDTH-1:0] dataout,
    output logic                  rvalid,
    output logic                  ready
);

    localparam logic [S_INDEX-1:0] LAST_SET = '1;

    state_e             state;
    logic [S_INDEX-1:0] sweep_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_SET) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: ready <= 1'b1;
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // During INIT the banks see a forced full-mask zero write at the sweep index.
    logic                  in_init;
    logic                  rd_fire;
    logic [WAYS-1:0]       bank_we;
    logic [WIDTH/8-1:0]    bank_mbe;
    logic [WIDTH-1:0]      bank_wdata;
    logic [S_INDEX-1:0]    bank_index;
    logic [WIDTH-1:0]      word    [WAYS];
    logic [WIDTH-1:0]      merged  [WAYS];
    logic [WIDTH-1:0]      rd_next [WAYS];
    logic [WAYS*WIDTH-1:0] stage1;
    logic                  rv1;

    assign in_init    = (state == INIT);
    assign rd_fire    = (state == READY) && read;
    assign bank_we    = in_init ? '1 : load;
    assign bank_mbe   = in_init ? '1 : mbe;
    assign bank_wdata = in_init ? '0 : datain;
    assign bank_index = in_init ? sweep_cnt : index;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        // Write-first: a way being loaded this cycle returns the byte-merged new value.
        assign rd_next[w] = bank_we[w] ? merged[w] : word[w];

        l2_way_bank #(
            .S_INDEX (S_INDEX),
            .WIDTH   (WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .index   (bank_index),
            .we      (bank_we[w]),
            .mbe     (bank_mbe),
            .wdata   (bank_wdata),
            .word    (word[w]),
            .merged  (merged[w]),
            .re      (rd_fire),
            .rd_next (rd_next[w]),
            .rdata   (stage1[w*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1 <= 1'b0;
        end else begin
            rv1 <= rd_fire;
        end
    end

`ifdef L2_ARRAY_OUTREG_EN
    logic [WAYS*WIDTH-1:0] stage2;
    logic                  rv2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage2 <= '0;
            rv2    <= 1'b0;
        end else begin
            rv2 <= rv1;
            if (rv1) begin
                stage2 <= stage1;
            end
        end
    end

    assign dataout = stage2;
    assign rvalid  = rv2;
`else
    assign dataout = stage1;
    assign rvalid  = rv1;
`endif

endmodule

// File: tb/tb_l2_array_mw.sv
// Directed + random bench for l2_array_mw with a reference model and expected-read scoreboard.
module tb_l2_array_mw;

    localparam int SI = 3;
    localparam int W  = 256;
    localparam int WY = 4;
    localparam int NB = W / 8;
    localparam int NS = 2**SI;
`ifdef L2_ARRAY_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            read;
    logic [WY-1:0]   load;
    logic [NB-1:0]   mbe;
    logic [SI-1:0]   index;
    logic [W-1:0]    datain;
    logic [WY*W-1:0] dataout;
    logic            rvalid;
    logic            ready;

    l2_array_mw #(.S_INDEX(SI), .WIDTH(W), .WAYS(WY)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .read    (read),
        .load    (load),
        .mbe     (mbe),
        .index   (index),
        .datain  (datain),
        .dataout (dataout),
        .rvalid  (rvalid),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    int              passed = 0;
    int              failed = 0;
    int              total  = 0;
    logic [W-1:0]    mdl [WY][NS];
    logic [WY*W-1:0] sb [$];
    logic [WY*W-1:0] exp_dout;
    logic [1:0]      pipe;
    logic            exp_ready;
    int              init_left;

    function automatic logic [W-1:0] mrg(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [NB-1:0] m);
        logic [W-1:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = m[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_dout(input string tag, input logic [WY*W-1:0] obs, input logic [WY*W-1:0] exp);
        int bad;
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            bad = 0;
            for (int w = WY - 1; w >= 0; w--) if (obs[w*W +: W] !== exp[w*W +: W]) bad = w;
            $error("FAIL %s way%0d observed=%h expected=%h", tag, bad, obs[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    // One clock: drive inputs, update model/scoreboard, then check outputs 1 time unit after the edge.
    task automatic cyc(input logic rd, input logic [WY-1:0] ld, input logic [NB-1:0] mb,
                       input logic [SI-1:0] idx, input logic [W-1:0] din);
        logic [WY*W-1:0] e;
        logic [W-1:0]    v;
        logic            issued;
        read = rd; load = ld; mbe = mb; index = idx; datain = din;
        e = '0;
        issued = exp_ready && rd;
        if (exp_ready) begin
            for (int w = 0; w < WY; w++) begin
                v = ld[w] ? mrg(mdl[w][idx], din, mb) : mdl[w][idx];
                e[w*W +: W] = v;
                if (ld[w]) mdl[w][idx] = v;
            end
            if (issued) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (init_left > 0) init_left--;
        exp_ready = (init_left == 0);
        pipe = {pipe[0], issued};
        if (pipe[LAT-1]) begin
            if (sb.size() == 0) begin
                total++;
                failed++;
                $error("FAIL scoreboard_empty observed=rvalid expected=pending_read");
            end else begin
                exp_dout = sb.pop_front();
            end
        end
        check_bit("ready", ready, exp_ready);
        check_bit("rvalid", rvalid, pipe[LAT-1]);
        check_dout("dataout", dataout, exp_dout);
        read = 1'b0;
        load = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_rvalid", rvalid, 1'b0);
        check_dout("rst_dataout", dataout, '0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        init_left = NS;
        exp_ready = 1'b0;
        pipe      = '0;
        exp_dout  = '0;
        sb.delete();
        for (int w = 0; w < WY; w++) for (int s = 0; s < NS; s++) mdl[w][s] = '0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; read = 1'b0; load = '0; mbe = '0; index = '0; datain = '0;
        #2;
        do_reset();

        // INIT lasts NS cycles; then every set reads back as zero, back-to-back.
        idle(NS);
        for (int i = 0; i < NS; i++) cyc(1'b1, '0, '0, SI'(i), '0);
        idle(LAT + 1);

        // Single-way full write, then read.
        cyc(1'b0, 4'b0010, '1, 3'd5, {NB{8'hA5}});
        cyc(1'b1, 4'b0000, '0, 3'd5, '0);
        idle(LAT + 1);

        // Byte-masked overwrite keeps unmasked bytes.
        cyc(1'b0, 4'b0001, '1, 3'd2, {NB{8'h11}});
        cyc(1'b0, 4'b0001, 32'h0000_0001, 3'd2, {NB{8'hFF}});
        cyc(1'b1, 4'b0000, '0, 3'd2, '0);
        idle(LAT + 1);

        // Write-first collision on way3 with partial mask; other ways keep prior contents.
        cyc(1'b0, 4'b1111, '1, 3'd7, {NB{8'h33}});
        cyc(1'b1, 4'b1000, 32'h00FF_00FF, 3'd7, {8{32'hDEAD_BEEF}});
        cyc(1'b1, 4'b0000, '0, 3'd7, '0);
        idle(LAT + 1);

        // mbe=0 load leaves storage untouched.
        cyc(1'b0, 4'b1111, '0, 3'd5, '1);
        cyc(1'b1, 4'b0000, '0, 3'd5, '0);
        idle(LAT + 1);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            cyc(1'($urandom), 4'($urandom), (i % 4 == 0) ? '1 : NB'($urandom),
                SI'($urandom), rnd_word());
        end
        idle(LAT + 1);

        // Reset while dataout is non-zero and rvalid is high, then again mid-sweep.
        cyc(1'b1, 4'b0000, '0, 3'd5, '0);
        if (LAT > 1) idle(LAT - 1);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1111, '1, 3'd0, '1);
        do_reset();
        for (int i = 0; i < NS; i++) cyc(1'b1, 4'b1111, '1, 3'd0, '1);
        for (int i = 0; i < NS; i++) cyc(1'b1, '0, '0, SI'(i), '0);
        idle(LAT + 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
